// File: rtl/line_mem_ctrl.sv
// Memory-side line responder: optional dirty-victim writeback, then a line fill,
// both sequenced as single-word beats into a synchronous single-port word RAM.
module line_mem_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int RAM_AW     = 12,
  parameter int RAM_LAT    = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_wb_i,
  input  logic [31:0]               req_wb_addr_i,
  input  logic [32*LINE_WORDS-1:0]  req_wb_words_i,
  input  logic [31:0]               req_addr_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [32*LINE_WORDS-1:0]  resp_words_o,
  output logic [RAM_AW-1:0]         ram_addr_o,
  output logic                      ram_we_o,
  output logic [31:0]               ram_wdata_o,
  input  logic [31:0]               ram_rdata_i
);

  localparam int BW  = $clog2(LINE_WORDS);
  localparam int LNW = RAM_AW - BW;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t             state_q;
  logic [BW-1:0]      beat_q;
  logic [BW-1:0]      beat_d;
  logic               last_beat;
  logic [LNW-1:0]     wb_line_q;
  logic [LNW-1:0]     fill_line_q;
  logic [31:0]        wb_words_q [LINE_WORDS];
  logic [31:0]        resp_words_q [LINE_WORDS];
  logic               req_ready_q;
  logic               resp_valid_q;
  logic [RAM_AW-1:0]  ram_addr_q;
  logic               ram_we_q;
  logic [31:0]        ram_wdata_q;
  logic               iss_vld_q;
  logic [BW-1:0]      iss_beat_q;
  logic [RAM_LAT-1:0] pipe_vld_q;
  logic [BW-1:0]      pipe_beat_q [RAM_LAT];
  logic               pipe_busy_d;
  logic               capture;
  logic               unused_addr_bits;

  // Byte offset and beat field are replaced by the beat counter; bits above the RAM are dropped.
  assign unused_addr_bits = ^{req_wb_addr_i[31:RAM_AW+2], req_wb_addr_i[BW+1:0],
                              req_addr_i[31:RAM_AW+2], req_addr_i[BW+1:0]};

  assign beat_d    = beat_q + BW'(1);
  assign last_beat = (beat_q == BW'(LINE_WORDS - 1));
  assign capture   = pipe_vld_q[RAM_LAT-1] && ((state_q == RD) || (state_q == DRAIN));

  // True while some read will still be in flight after the coming edge (the exiting slot excluded).
  always_comb begin
    pipe_busy_d = iss_vld_q;
    for (int i = 0; i < RAM_LAT - 1; i++) begin
      pipe_busy_d = pipe_busy_d | pipe_vld_q[i];
    end
  end

  // iss_* tags the address currently on the RAM bus; the pipe then ages it RAM_LAT edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iss_vld_q  <= 1'b0;
      iss_beat_q <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < RAM_LAT; i++) begin
        pipe_beat_q[i] <= '0;
      end
    end else begin
      iss_vld_q      <= (state_q == RD);
      iss_beat_q     <= beat_q;
      pipe_vld_q[0]  <= iss_vld_q;
      pipe_beat_q[0] <= iss_beat_q;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_beat_q[i] <= pipe_beat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      wb_line_q    <= '0;
      fill_line_q  <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        wb_words_q[i]   <= '0;
        resp_words_q[i] <= '0;
      end
    end else begin
      if (capture) begin
        resp_words_q[pipe_beat_q[RAM_LAT-1]] <= ram_rdata_i;
      end
      case (state_q)
        IDLE: begin
          ram_we_q <= 1'b0;
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            beat_q      <= '0;
            wb_line_q   <= req_wb_addr_i[RAM_AW+1:BW+2];
            fill_line_q <= req_addr_i[RAM_AW+1:BW+2];
            for (int i = 0; i < LINE_WORDS; i++) begin
              wb_words_q[i] <= req_wb_words_i[i*32 +: 32];
            end
            state_q <= req_wb_i ? WB : RD;
          end
        end
        WB: begin
          ram_we_q    <= 1'b1;
          ram_addr_q  <= {wb_line_q, beat_q};
          ram_wdata_q <= wb_words_q[beat_q];
          beat_q      <= beat_d;
          if (last_beat) begin
            state_q <= RD;
          end
        end
        RD: begin
          ram_we_q   <= 1'b0;
          ram_addr_q <= {fill_line_q, beat_q};
          beat_q     <= beat_d;
          if (last_beat) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          ram_we_q <= 1'b0;
          if (!pipe_busy_d) begin
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          ram_we_q <= 1'b0;
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          ram_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_resp
    assign resp_words_o[g*32 +: 32] = resp_words_q[g];
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_we_o     = ram_we_q;
  assign ram_wdata_o  = ram_wdata_q;

endmodule
